// File: rtl/sized_fifo0_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sized_fifo0_pkg
// Brief   : Shared types and helpers for the zero-data-width burst FIFO tracker
// Revision: 1.0
// ============================================================================
package sized_fifo0_pkg;

    // Default capacity; an empty FIFO reports its whole depth as free space.
    localparam int c_DEF_DEPTH     = 16;
    localparam int c_DEF_RST_SPACE = c_DEF_DEPTH;

    typedef struct packed {
        logic [31:0] count_next;
        logic        enq_ok;
        logic        deq_ok;
    } nc_t;

    function automatic int clog2_f(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Arithmetic is 32 bits wide so no intermediate sum can wrap; the caller
    // keeps only the low counter bits, which always hold 0..depth.
    function automatic nc_t next_count(
        input logic [31:0] count,
        input logic [31:0] enq,
        input logic [31:0] deq,
        input logic        guarded,
        input logic [31:0] depth
    );
        nc_t         res;
        logic [31:0] deq_eff;
        logic [31:0] enq_eff;
        res.deq_ok = (deq <= count);
        deq_eff    = res.deq_ok ? deq : 32'd0;
        if (guarded) begin
            res.enq_ok = ((count + enq) <= depth);
        end else begin
            res.enq_ok = ((count - deq_eff + enq) <= depth);
        end
        enq_eff        = res.enq_ok ? enq : 32'd0;
        res.count_next = count + enq_eff - deq_eff;
        return res;
    endfunction

endpackage : sized_fifo0_pkg
`default_nettype wire

// File: rtl/sized_fifo0_flag_gen.sv
`default_nettype none
// ============================================================================
// Module  : sized_fifo0_flag_gen
// Brief   : Combinational next-state flags and free space from next occupancy
// Revision: 1.0
// ============================================================================
module sized_fifo0_flag_gen #(
    parameter int DEPTH      = 16,
    parameter int CNTR_WIDTH = 5
) (
    input  logic [CNTR_WIDTH-1:0] i_count_next,
    input  logic [CNTR_WIDTH-1:0] i_afull_thresh,
    input  logic [CNTR_WIDTH-1:0] i_aempty_thresh,
    output logic                  o_full_n,
    output logic                  o_empty_n,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [CNTR_WIDTH-1:0] o_space
);

    localparam logic [CNTR_WIDTH-1:0] c_DEPTH = CNTR_WIDTH'(DEPTH);

    always_comb begin
        o_full_n       = (i_count_next != c_DEPTH);
        o_empty_n      = (i_count_next != '0);
        o_almost_full  = (i_count_next >= i_afull_thresh);
        o_almost_empty = (i_count_next <= i_aempty_thresh);
        o_space        = c_DEPTH - i_count_next;
    end

endmodule : sized_fifo0_flag_gen
`default_nettype wire

// File: rtl/sized_fifo0_burst.sv
`default_nettype none
// ============================================================================
// Module  : sized_fifo0_burst
// Brief   : Data-less FIFO occupancy tracker with multi-token enq/deq per cycle
// Revision: 1.0
// ============================================================================
module sized_fifo0_burst
    import sized_fifo0_pkg::*;
#(
    parameter int p1depth       = c_DEF_DEPTH,
    parameter int p2cntr_width  = 5,
    parameter int p3burst_width = 3,
    parameter bit guarded       = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic [p3burst_width-1:0] ENQ_NUM,
    input  logic [p3burst_width-1:0] DEQ_NUM,
    input  logic [p2cntr_width-1:0]  AFULL_THRESH,
    input  logic [p2cntr_width-1:0]  AEMPTY_THRESH,
    input  logic                     ERR_CLR,
    output logic [p2cntr_width-1:0]  COUNT,
    output logic [p2cntr_width-1:0]  SPACE,
    output logic                     FULL_N,
    output logic                     EMPTY_N,
    output logic                     ALMOST_FULL,
    output logic                     ALMOST_EMPTY,
    output logic                     ERR_OVF,
    output logic                     ERR_UDF
);

    localparam logic [p2cntr_width-1:0] c_RST_SPACE = p2cntr_width'(p1depth);

    if ((p1depth < 2) || (clog2_f(p1depth + 1) > p2cntr_width) ||
        (p3burst_width > p2cntr_width)) begin : g_param_check
        $error("sized_fifo0_burst: illegal parameter combination");
    end

    logic [p2cntr_width-1:0] r_count;
    logic [p2cntr_width-1:0] r_space;
    logic                    r_full_n;
    logic                    r_empty_n;
    logic                    r_afull;
    logic                    r_aempty;
    logic                    r_err_ovf;
    logic                    r_err_udf;

    nc_t                     w_nc;
    logic [p2cntr_width-1:0] w_count_next;
    logic                    w_ovf;
    logic                    w_udf;
    logic                    w_full_n;
    logic                    w_empty_n;
    logic                    w_afull;
    logic                    w_aempty;
    logic [p2cntr_width-1:0] w_space;
    logic [31:0]             w_nc_unused;

    always_comb begin
        w_nc         = next_count(32'(r_count), 32'(ENQ_NUM), 32'(DEQ_NUM),
                                  guarded, 32'(p1depth));
        w_count_next = w_nc.count_next[p2cntr_width-1:0];
        w_nc_unused  = w_nc.count_next;
        // A zero-token request is never an error.
        w_ovf        = (ENQ_NUM != '0) && !w_nc.enq_ok;
        w_udf        = (DEQ_NUM != '0) && !w_nc.deq_ok;
    end

    sized_fifo0_flag_gen #(
        .DEPTH      (p1depth),
        .CNTR_WIDTH (p2cntr_width)
    ) u_flag_gen (
        .i_count_next    (w_count_next),
        .i_afull_thresh  (AFULL_THRESH),
        .i_aempty_thresh (AEMPTY_THRESH),
        .o_full_n        (w_full_n),
        .o_empty_n       (w_empty_n),
        .o_almost_full   (w_afull),
        .o_almost_empty  (w_aempty),
        .o_space         (w_space)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count   <= '0;
            r_space   <= c_RST_SPACE;
            r_full_n  <= 1'b1;
            r_empty_n <= 1'b0;
            r_afull   <= 1'b0;
            r_aempty  <= 1'b1;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (CLR) begin
                r_count   <= '0;
                r_space   <= c_RST_SPACE;
                r_full_n  <= 1'b1;
                r_empty_n <= 1'b0;
                r_afull   <= 1'b0;
                r_aempty  <= 1'b1;
            end else begin
                r_count   <= w_count_next;
                r_space   <= w_space;
                r_full_n  <= w_full_n;
                r_empty_n <= w_empty_n;
                r_afull   <= w_afull;
                r_aempty  <= w_aempty;
            end
            // A fresh error outranks ERR_CLR; requests under CLR are discarded.
            r_err_ovf <= (r_err_ovf & ~ERR_CLR) | (w_ovf & ~CLR);
            r_err_udf <= (r_err_udf & ~ERR_CLR) | (w_udf & ~CLR);
        end
    end

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (!RST && !CLR && w_ovf) begin
            $warning("%m: enqueue of %0d tokens rejected at count %0d", ENQ_NUM, r_count);
        end
        if (!RST && !CLR && w_udf) begin
            $warning("%m: dequeue of %0d tokens rejected at count %0d", DEQ_NUM, r_count);
        end
    end
`endif

    assign COUNT        = r_count;
    assign SPACE        = r_space;
    assign FULL_N       = r_full_n;
    assign EMPTY_N      = r_empty_n;
    assign ALMOST_FULL  = r_afull;
    assign ALMOST_EMPTY = r_aempty;
    assign ERR_OVF      = r_err_ovf;
    assign ERR_UDF      = r_err_udf;

endmodule : sized_fifo0_burst
`default_nettype wire

// File: tb/tb_sized_fifo0_burst.sv
`default_nettype none
// ============================================================================
// Module  : tb_sized_fifo0_burst
// Brief   : Directed bench for guarded and unguarded burst FIFO trackers
// Revision: 1.0
// ============================================================================
module tb_sized_fifo0_burst;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CLR;
    logic       ERR_CLR;
    logic [2:0] ENQ_NUM;
    logic [2:0] DEQ_NUM;
    logic [4:0] AFULL_THRESH;
    logic [4:0] AEMPTY_THRESH;

    logic [4:0] count_g, space_g, count_u, space_u;
    logic       full_n_g, empty_n_g, af_g, ae_g, ovf_g, udf_g;
    logic       full_n_u, empty_n_u, af_u, ae_u, ovf_u, udf_u;

    int checks   = 0;
    int failures = 0;

    sized_fifo0_burst #(.p1depth(16), .p2cntr_width(5), .p3burst_width(3), .guarded(1'b1)) dut_g (
        .CLK(CLK), .RST(RST), .CLR(CLR), .ENQ_NUM(ENQ_NUM), .DEQ_NUM(DEQ_NUM),
        .AFULL_THRESH(AFULL_THRESH), .AEMPTY_THRESH(AEMPTY_THRESH), .ERR_CLR(ERR_CLR),
        .COUNT(count_g), .SPACE(space_g), .FULL_N(full_n_g), .EMPTY_N(empty_n_g),
        .ALMOST_FULL(af_g), .ALMOST_EMPTY(ae_g), .ERR_OVF(ovf_g), .ERR_UDF(udf_g)
    );

    sized_fifo0_burst #(.p1depth(16), .p2cntr_width(5), .p3burst_width(3), .guarded(1'b0)) dut_u (
        .CLK(CLK), .RST(RST), .CLR(CLR), .ENQ_NUM(ENQ_NUM), .DEQ_NUM(DEQ_NUM),
        .AFULL_THRESH(AFULL_THRESH), .AEMPTY_THRESH(AEMPTY_THRESH), .ERR_CLR(ERR_CLR),
        .COUNT(count_u), .SPACE(space_u), .FULL_N(full_n_u), .EMPTY_N(empty_n_u),
        .ALMOST_FULL(af_u), .ALMOST_EMPTY(ae_u), .ERR_OVF(ovf_u), .ERR_UDF(udf_u)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Flags follow directly from the expected occupancy and the current thresholds.
    task automatic check_dut(input string tag, input bit g, input int c, input int ovf, input int udf);
        string p;
        p = g ? {tag, ".g"} : {tag, ".u"};
        check({p, ".count"},   g ? 32'(count_g)   : 32'(count_u),   32'(c));
        check({p, ".space"},   g ? 32'(space_g)   : 32'(space_u),   32'(16 - c));
        check({p, ".full_n"},  g ? 32'(full_n_g)  : 32'(full_n_u),  32'(c != 16));
        check({p, ".empty_n"}, g ? 32'(empty_n_g) : 32'(empty_n_u), 32'(c != 0));
        check({p, ".afull"},   g ? 32'(af_g)      : 32'(af_u),      32'(c >= int'(AFULL_THRESH)));
        check({p, ".aempty"},  g ? 32'(ae_g)      : 32'(ae_u),      32'(c <= int'(AEMPTY_THRESH)));
        check({p, ".ovf"},     g ? 32'(ovf_g)     : 32'(ovf_u),     32'(ovf));
        check({p, ".udf"},     g ? 32'(udf_g)     : 32'(udf_u),     32'(udf));
    endtask

    task automatic step(input int enq, input int deq, input bit clr, input bit ec);
        ENQ_NUM = 3'(enq);
        DEQ_NUM = 3'(deq);
        CLR     = clr;
        ERR_CLR = ec;
        @(posedge CLK);
        #1;
        ENQ_NUM = '0;
        DEQ_NUM = '0;
        CLR     = 1'b0;
        ERR_CLR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; CLR = 1'b0; ERR_CLR = 1'b0; ENQ_NUM = '0; DEQ_NUM = '0;
        AFULL_THRESH = 5'd12; AEMPTY_THRESH = 5'd1;
        step(3, 2, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0);
        RST = 1'b0;
        check_dut("reset", 1, 0, 0, 0);
        check_dut("reset", 0, 0, 0, 0);

        step(5, 0, 0, 0); check_dut("enq5a", 1, 5, 0, 0);  check_dut("enq5a", 0, 5, 0, 0);
        step(5, 0, 0, 0); check_dut("enq5b", 1, 10, 0, 0); check_dut("enq5b", 0, 10, 0, 0);
        step(5, 0, 0, 0); check_dut("enq5c", 1, 15, 0, 0); check_dut("enq5c", 0, 15, 0, 0);

        step(2, 3, 0, 0); check_dut("guard", 1, 12, 1, 0); check_dut("guard", 0, 14, 0, 0);

        step(0, 0, 1, 0); check_dut("clr", 1, 0, 1, 0); check_dut("clr", 0, 0, 0, 0);
        step(0, 0, 0, 1); check_dut("errclr1", 1, 0, 0, 0);

        step(2, 0, 0, 0); check_dut("fill2", 1, 2, 0, 0);
        step(0, 3, 0, 0); check_dut("udf", 1, 2, 0, 1); check_dut("udf", 0, 2, 0, 1);
        step(0, 2, 0, 0); check_dut("drain", 1, 0, 0, 1); check_dut("drain", 0, 0, 0, 1);
        step(0, 3, 0, 1); check_dut("errwins", 1, 0, 0, 1);
        step(0, 0, 0, 1); check_dut("errclr2", 1, 0, 0, 0); check_dut("errclr2", 0, 0, 0, 0);

        step(7, 0, 0, 0);
        step(7, 0, 0, 0);
        step(2, 0, 0, 0); check_dut("full", 1, 16, 0, 0); check_dut("full", 0, 16, 0, 0);
        step(4, 4, 0, 0); check_dut("fullswap", 1, 12, 1, 0); check_dut("fullswap", 0, 16, 0, 0);

        step(0, 3, 0, 0); check_dut("to9", 1, 9, 1, 0); check_dut("to9", 0, 13, 0, 0);
        step(3, 0, 1, 0); check_dut("clrenq", 1, 0, 1, 0); check_dut("clrenq", 0, 0, 0, 0);
        step(0, 0, 0, 1); check_dut("errclr3", 1, 0, 0, 0);

        AFULL_THRESH = 5'd10;
        step(7, 0, 0, 0);
        step(1, 0, 0, 0); check_dut("idle8", 1, 8, 0, 0);
        AFULL_THRESH  = 5'd8;
        AEMPTY_THRESH = 5'd8;
        step(0, 0, 0, 0); check_dut("thresh", 1, 8, 0, 0); check_dut("thresh", 0, 8, 0, 0);
        check("thresh.af_g", 32'(af_g), 32'd1);

        RST = 1'b1;
        step(7, 0, 0, 0);
        RST = 1'b0;
        check_dut("rstburst", 1, 0, 0, 0); check_dut("rstburst", 0, 0, 0, 0);
        check("rstburst.ae_g", 32'(ae_g), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sized_fifo0_burst
`default_nettype wire

// File: doc/sized_fifo0_burst.md
Name: sized_fifo0_burst

Overview:
- Parametrised zero-data-width FIFO occupancy tracker.
- Tracks an occupancy count for a data-less FIFO, like the single-token counter FIFOs already in the library.
- Adds multi-token enqueue/dequeue per cycle, programmable almost-full/almost-empty flags, a registered occupancy/space readout and sticky overflow/underflow error flags.
- Used by credit-return and flow-control paths where beats are tracked but no payload is stored.

Parameters:
- p1depth, 16, FIFO capacity in tokens; legal range 2..(2^p2cntr_width - 1).
- p2cntr_width, 5, count width; must satisfy 2^p2cntr_width > p1depth.
- p3burst_width, 3, width of ENQ_NUM/DEQ_NUM; max tokens per op is 2^p3burst_width - 1; must be <= p2cntr_width.
- guarded, 1, 1: enqueue admission ignores same-cycle dequeue; 0: same-cycle dequeue frees space for enqueue.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- CLR  in  1  synchronous clear of occupancy
- ENQ_NUM  in  p3burst_width  tokens to enqueue this cycle (0 = none)
- DEQ_NUM  in  p3burst_width  tokens to dequeue this cycle (0 = none)
- AFULL_THRESH  in  p2cntr_width  almost-full threshold
- AEMPTY_THRESH  in  p2cntr_width  almost-empty threshold
- ERR_CLR  in  1  clears sticky error flags
- COUNT  out  p2cntr_width  registered occupancy
- SPACE  out  p2cntr_width  registered p1depth - COUNT
- FULL_N  out  1  COUNT != p1depth
- EMPTY_N  out  1  COUNT != 0
- ALMOST_FULL  out  1  COUNT >= AFULL_THRESH
- ALMOST_EMPTY  out  1  COUNT <= AEMPTY_THRESH
- ERR_OVF  out  1  sticky: an enqueue was rejected
- ERR_UDF  out  1  sticky: a dequeue was rejected

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high, sampled on the CLK rising edge.
- All outputs are registers; none is combinational from inputs.
- Reset values:
  - COUNT=0, SPACE=p1depth
  - FULL_N=1, EMPTY_N=0
  - ALMOST_FULL=0, ALMOST_EMPTY=1
  - ERR_OVF=0, ERR_UDF=0
- Priority per edge: RST > CLR > ENQ/DEQ update.
- CLR gives the same occupancy and flag values as reset.
- CLR preserves ERR_OVF/ERR_UDF.
- ERR_CLR clears both error flags. It is independent of CLR. A new error raised in the same cycle as ERR_CLR wins, so the flag stays 1.
- Dequeue admission: deq_ok = (DEQ_NUM <= COUNT). All-or-nothing; no partial dequeue.
- Enqueue admission:
  - guarded=1: enq_ok = (COUNT + ENQ_NUM <= p1depth).
  - guarded=0: enq_ok = (COUNT - (deq_ok ? DEQ_NUM : 0) + ENQ_NUM <= p1depth).
- A rejected request (nonzero NUM, ok=0):
  - leaves COUNT unaffected by that request;
  - sets the matching sticky error;
  - prints a simulation-only warning naming the instance, outside synthesis.
- A NUM of 0 is never an error.
- Next count: COUNT_next = COUNT + (enq_ok ? ENQ_NUM : 0) - (deq_ok ? DEQ_NUM : 0).
  - Compute in p2cntr_width+1 bits so nothing wraps.
  - The result is always within 0..p1depth.
- Latency: all flags and SPACE are computed from COUNT_next and registered in the same edge, so they are valid one cycle after the request, together with COUNT.
- Thresholds:
  - Sampled at the edge and compared against COUNT_next.
  - A threshold change alone updates ALMOST_* at the next edge, even with no ENQ/DEQ.
  - Thresholds outside 0..p1depth are legal: AFULL_THRESH > p1depth keeps ALMOST_FULL=0.
- Simultaneous ENQ and DEQ with equal NUM, both accepted: COUNT and all flags are unchanged.
- RST asserted mid-burst discards that cycle's requests.
- Inputs during RST are ignored and raise no errors.

Decomposition:
- Shared package holds:
  - constant helper clog2-style function for checking p2cntr_width;
  - a next-count function taking (count, enq, deq, guarded, depth) and returning {count_next, enq_ok, deq_ok};
  - localparam for the reset SPACE value.
- One natural sub-module, sized_fifo0_flag_gen: purely combinational.
  - Inputs: COUNT_next and thresholds.
  - Outputs: next FULL_N, EMPTY_N, ALMOST_FULL, ALMOST_EMPTY, SPACE, which the top registers.
- Elaboration-time parameter check: reject p1depth < 2, 2^p2cntr_width <= p1depth, and p3burst_width > p2cntr_width.

Test Plan:
1. Reset then ENQ_NUM=5 for 3 cycles (depth 16) -> COUNT 5,10,15. FULL_N=1 throughout. ALMOST_FULL rises when COUNT=15 (AFULL_THRESH=12 → already 1 at COUNT=15, 0 at COUNT=10).
2. COUNT=15, guarded=1, ENQ_NUM=2 with DEQ_NUM=3 -> enqueue rejected, COUNT=12, ERR_OVF=1. Same stimulus with guarded=0 -> COUNT=14, ERR_OVF=0.
3. COUNT=2, DEQ_NUM=3 -> COUNT stays 2, ERR_UDF=1. Then DEQ_NUM=2 -> COUNT=0, EMPTY_N=0, ALMOST_EMPTY=1 (AEMPTY_THRESH=1).
4. COUNT=16, ENQ_NUM=4 and DEQ_NUM=4, guarded=0 -> COUNT=16, FULL_N=0, no error. Same with guarded=1 -> COUNT=12, ERR_OVF=1.
5. COUNT=9 with ERR_OVF=1, then CLR with ENQ_NUM=3 -> COUNT=0, SPACE=16, ERR_OVF stays 1. Then ERR_CLR -> ERR_OVF=0.
6. Idle at COUNT=8, change AFULL_THRESH 10→8 -> ALMOST_FULL=1 one edge later. Assert RST with ENQ_NUM=7 -> all reset values, COUNT=0.
